// File: rtl/la_pwrseq_pkg.sv
// Shared types for the power-domain sequencer.
// State encoding and counter sizing helpers.
package la_pwrseq_pkg;

   typedef enum logic [3:0] {
      S_OFF,
      S_UP,
      S_ACK,
      S_UNRST,
      S_UNISO,
      S_ON,
      S_CLAMP,
      S_DOWN,
      S_ERR
   } state_t;

   localparam int TIMEOUT_DEF = 255;
   localparam int CW_MIN      = 16;

   function automatic int cnt_w(input int dw);
      return (dw > CW_MIN) ? dw : CW_MIN;
   endfunction

endpackage

// File: rtl/la_pwrseq_cnt.sv
// Loadable down-counter with zero flag.
// Shared between switch-step delay and sw_ack timeout.
module la_pwrseq_cnt
   import la_pwrseq_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // load wins; otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: staged switch ramp, reset and isolation
// ordering for one switchable domain, from the always-on domain.
module la_pwrseq
   import la_pwrseq_pkg::*;
#(
   parameter int    N       = 4,
   parameter int    DW      = 8,
   parameter int    TIMEOUT = TIMEOUT_DEF,
   parameter string PROP    = "DEFAULT"
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          on_req,
   input  logic [DW-1:0] dly,
   input  logic          sw_ack,
   output logic [N-1:0]  sw_en,
   output logic          dom_nreset,
   output logic          iso,
   output logic          pwr_on,
   output logic          busy,
   output logic          err
);

   localparam int            CW    = cnt_w(DW);
   localparam logic [N-1:0]  FULL  = '1;
   localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT - 1);
   localparam bit            PROP_DEF = (PROP == "DEFAULT");

   // PROP is an implementation tag only; no logic depends on it
   if (!PROP_DEF) begin : g_prop_custom
   end

   state_t        state;
   state_t        state_nx;
   logic [N-1:0]  sw_en_nx;
   logic [N-1:0]  sw_up;
   logic [N-1:0]  sw_dn;
   logic          nrst_nx;
   logic          iso_nx;
   logic          pwr_nx;
   logic          busy_nx;
   logic          err_nx;
   logic          ld;
   logic [CW-1:0] ld_val;
   logic [CW-1:0] step_ld;
   logic          zero;

   // counter loads D-1 so a step lands exactly D cycles after the load
   assign step_ld = (dly == '0) ? '0 : CW'(dly - DW'(1));
   assign sw_up   = (sw_en << 1) | N'(1);
   assign sw_dn   = sw_en >> 1;

   la_pwrseq_cnt #(.W(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .val   (ld_val),
      .zero  (zero)
   );

   // next-state and next-output decode
   always_comb begin
      state_nx = state;
      sw_en_nx = sw_en;
      nrst_nx  = dom_nreset;
      iso_nx   = iso;
      pwr_nx   = pwr_on;
      err_nx   = err;
      ld       = 1'b0;
      ld_val   = step_ld;
      unique case (state)
         S_OFF: begin
            if (on_req) begin
               state_nx = S_UP;
               sw_en_nx = N'(1);
               ld       = 1'b1;
            end
         end
         S_UP: begin
            if (!on_req) begin
               state_nx = S_DOWN;
               ld       = 1'b1;
            end else if (zero) begin
               ld = 1'b1;
               if (sw_en == FULL) begin
                  state_nx = S_ACK;
                  ld_val   = TO_LD;
               end else begin
                  sw_en_nx = sw_up;
               end
            end
         end
         S_ACK: begin
            if (!on_req) begin
               state_nx = S_DOWN;
               ld       = 1'b1;
            end else if (sw_ack) begin
               state_nx = S_UNRST;
               nrst_nx  = 1'b1;
            end else if (zero) begin
               state_nx = S_ERR;
               sw_en_nx = '0;
               nrst_nx  = 1'b0;
               iso_nx   = 1'b1;
               err_nx   = 1'b1;
            end
         end
         S_UNRST: begin
            state_nx = S_UNISO;
            iso_nx   = 1'b0;
            pwr_nx   = 1'b1;
         end
         S_UNISO: begin
            state_nx = S_ON;
         end
         S_ON: begin
            if (!on_req) begin
               state_nx = S_CLAMP;
               pwr_nx   = 1'b0;
               iso_nx   = 1'b1;
            end
         end
         S_CLAMP: begin
            state_nx = S_DOWN;
            nrst_nx  = 1'b0;
            ld       = 1'b1;
         end
         S_DOWN: begin
            if (zero) begin
               sw_en_nx = sw_dn;
               ld       = 1'b1;
               if (sw_dn == '0)
                  state_nx = S_OFF;
            end
         end
         S_ERR: begin
            sw_en_nx = '0;
            nrst_nx  = 1'b0;
            iso_nx   = 1'b1;
            err_nx   = 1'b1;
            if (!on_req)
               state_nx = S_OFF;
         end
         default: begin
            state_nx = S_OFF;
            sw_en_nx = '0;
            nrst_nx  = 1'b0;
            iso_nx   = 1'b1;
            pwr_nx   = 1'b0;
         end
      endcase
      busy_nx = !(state_nx == S_OFF || state_nx == S_ON ||
                  state_nx == S_ERR);
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OFF;
         sw_en      <= '0;
         dom_nreset <= 1'b0;
         iso        <= 1'b1;
         pwr_on     <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         sw_en      <= sw_en_nx;
         dom_nreset <= nrst_nx;
         iso        <= iso_nx;
         pwr_on     <= pwr_nx;
         busy       <= busy_nx;
         err        <= err_nx;
      end
   end

endmodule
